// File: rtl/peripheral_system_debounced_pio.sv
// Debounced parallel input port: synchronizes and debounces WIDTH inputs, captures
// enabled rise/fall edges and raises a level interrupt through a small register map.
module peripheral_system_debounced_pio #(
    parameter int unsigned      WIDTH           = 3,
    parameter int unsigned      DEBOUNCE_CYCLES = 1000,
    parameter logic [WIDTH-1:0] RISE_EN_RESET   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq,
    output logic [31:0]      readdata
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [2:0] ADDR_DEB     = 3'd0;
    localparam logic [2:0] ADDR_RAW     = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_CAP     = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN = 3'd5;

    logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [WIDTH-1:0] deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] wdata, rise_evt, fall_evt;
    logic             wr_en;
    logic             unused_wdata;

    assign unused_wdata = &{1'b0, writedata};

    // Per-bit debounce: deb follows s2 only after it has differed for DEBOUNCE_CYCLES clocks
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign deb_d = s2_q;
    end else begin : g_cnt
        logic [CNT_W-1:0] cnt_q [WIDTH];
        logic [CNT_W-1:0] cnt_d [WIDTH];

        always_comb begin
            deb_d = deb_q;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_d[i] = cnt_q[i];
                if (s2_q[i] == deb_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = s2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
            end else begin
                for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rise_evt = deb_q & ~deb_prev_q & rise_en_q;
    assign fall_evt = ~deb_q & deb_prev_q & fall_en_q;

    // Register writes, edge capture (set wins over clear) and read mux
    always_comb begin
        s1_d       = in_port;
        s2_d       = s1_q;
        deb_prev_d = deb_q;
        wr_en      = chipselect & ~write_n;
        wdata      = writedata[WIDTH-1:0];
        mask_d     = mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        cap_d      = cap_q;
        readdata_d = '0;

        if (wr_en) begin
            case (address)
                ADDR_MASK:    mask_d    = wdata;
                ADDR_CAP:     cap_d     = cap_q & ~wdata;
                ADDR_RISE_EN: rise_en_d = wdata;
                ADDR_FALL_EN: fall_en_d = wdata;
                default:      ;
            endcase
        end
        cap_d = cap_d | rise_evt | fall_evt;

        case (address)
            ADDR_DEB:     readdata_d = 32'(deb_q);
            ADDR_RAW:     readdata_d = 32'(s2_q);
            ADDR_MASK:    readdata_d = 32'(mask_q);
            ADDR_CAP:     readdata_d = 32'(cap_q);
            ADDR_RISE_EN: readdata_d = 32'(rise_en_q);
            ADDR_FALL_EN: readdata_d = 32'(fall_en_q);
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            rise_en_q  <= RISE_EN_RESET;
            fall_en_q  <= '0;
            readdata_q <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_peripheral_system_debounced_pio.sv
// Bench for the debounced PIO: reads push expected {irq, readdata} into a queue and a
// monitor pops and compares one cycle later. Two instances: debounce 4 and bypass.
module tb_peripheral_system_debounced_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [2:0]  in0 = '0;
    logic [2:0]  in1 = '0;
    logic        irq0, irq1;
    logic [31:0] rd0, rd1;

    always #5 clk = ~clk;

    peripheral_system_debounced_pio #(.WIDTH(3), .DEBOUNCE_CYCLES(4)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in0), .irq(irq0), .readdata(rd0)
    );

    peripheral_system_debounced_pio #(.WIDTH(3), .DEBOUNCE_CYCLES(0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in1), .irq(irq1), .readdata(rd1)
    );

    typedef struct packed {
        logic        dut;
        logic        irq;
        logic [31:0] rd;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    logic  rd_vld = 1'b0;
    logic  rd_vld_q = 1'b0;

    task automatic chk(input string nm, input logic [32:0] got, input logic [32:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got irq=%0b rd=0x%08h, expected irq=%0b rd=0x%08h",
                     nm, got[32], got[31:0], exp[32], exp[31:0]);
        end
    endtask

    // Monitor: a read issued before edge k is presented after edge k
    always @(posedge clk) rd_vld_q <= rd_vld;

    always @(negedge clk) begin
        if (rd_vld_q) begin
            if (exp_q.size() == 0) begin
                chk("no_expectation", {irq0, rd0}, 33'h1_ffff_ffff);
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.dut) chk(nm, {irq1, rd1}, {e.irq, e.rd});
                else       chk(nm, {irq0, rd0}, {e.irq, e.rd});
            end
        end
    end

    task automatic rd(input logic [2:0] a, input logic [31:0] e_rd, input logic e_irq,
                      input string nm, input logic d);
        exp_t e;
        e.dut = d; e.irq = e_irq; e.rd = e_rd;
        address    = a;
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd_vld     = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        rd_vld = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        idle(2);
        chk("reset_outputs", {irq0, rd0}, 33'h0);
        reset_n = 1'b1;
        rd(3'd0, 32'd0, 1'b0, "rst_deb", 1'b0);
        rd(3'd1, 32'd0, 1'b0, "rst_raw", 1'b0);
        rd(3'd2, 32'd0, 1'b0, "rst_mask", 1'b0);
        rd(3'd3, 32'd0, 1'b0, "rst_cap", 1'b0);
        rd(3'd4, 32'd7, 1'b0, "rst_rise_en", 1'b0);
        rd(3'd5, 32'd0, 1'b0, "rst_fall_en", 1'b0);
        rd(3'd7, 32'd0, 1'b0, "rst_addr7", 1'b0);
        wr(3'd2, 32'd1);

        // Bypass instance: deb after edge 2, capture after edge 3
        in1 = 3'b001;
        for (int k = 0; k < 5; k++)
            rd(3'd0, (k >= 3) ? 32'd1 : 32'd0, k >= 3, $sformatf("bypass_e%0d", k), 1'b1);

        // Rise on bit 0: deb after edge 5 (visible in read at edge 6), capture after edge 6
        in0 = 3'b001;
        for (int i = 0; i < 9; i++)
            rd(3'd0, (i >= 6) ? 32'd1 : 32'd0, i >= 6, $sformatf("rise0_e%0d", i), 1'b0);
        rd(3'd3, 32'd1, 1'b1, "rise0_cap", 1'b0);
        rd(3'd1, 32'd1, 1'b1, "rise0_raw", 1'b0);
        wr(3'd3, 32'd1);
        rd(3'd3, 32'd0, 1'b0, "rise0_clr", 1'b0);

        // Three-cycle glitch on bit 1 is rejected
        wr(3'd2, 32'd7);
        in0 = 3'b011;
        for (int i = 0; i < 3; i++) rd(3'd0, 32'd1, 1'b0, $sformatf("glitch_hi%0d", i), 1'b0);
        in0 = 3'b001;
        for (int i = 0; i < 8; i++) rd(3'd0, 32'd1, 1'b0, $sformatf("glitch_lo%0d", i), 1'b0);
        rd(3'd3, 32'd0, 1'b0, "glitch_cap", 1'b0);

        // Fall-only capture on bit 2, then W1C
        wr(3'd5, 32'd4);
        wr(3'd4, 32'd0);
        in0 = 3'b101;
        for (int i = 0; i < 9; i++)
            rd(3'd0, (i >= 6) ? 32'd5 : 32'd1, 1'b0, $sformatf("fall_up_e%0d", i), 1'b0);
        in0 = 3'b001;
        for (int i = 0; i < 9; i++)
            rd(3'd0, (i >= 6) ? 32'd1 : 32'd5, i >= 6, $sformatf("fall_dn_e%0d", i), 1'b0);
        rd(3'd3, 32'd4, 1'b1, "fall_cap", 1'b0);
        wr(3'd3, 32'd4);
        rd(3'd3, 32'd0, 1'b0, "fall_clr", 1'b0);

        // Clear in the same cycle as a new rise: set wins
        wr(3'd4, 32'd7);
        in0 = 3'b000;
        idle(10);
        rd(3'd3, 32'd0, 1'b0, "pre_race_cap", 1'b0);
        in0 = 3'b001;
        for (int i = 0; i < 6; i++) rd(3'd0, 32'd0, 1'b0, $sformatf("race_e%0d", i), 1'b0);
        wr(3'd3, 32'd1);
        rd(3'd3, 32'd1, 1'b1, "race_set_wins", 1'b0);
        wr(3'd3, 32'd0);
        rd(3'd3, 32'd1, 1'b1, "w0_keeps", 1'b0);

        // Enable changes keep captures; read-only and unused addresses ignore writes
        wr(3'd4, 32'd0);
        wr(3'd5, 32'd0);
        rd(3'd3, 32'd1, 1'b1, "en_change_keeps", 1'b0);
        wr(3'd0, 32'd6);
        wr(3'd1, 32'd6);
        rd(3'd0, 32'd1, 1'b1, "ro_deb", 1'b0);
        rd(3'd4, 32'd0, 1'b1, "rise_en_rb", 1'b0);
        rd(3'd6, 32'd0, 1'b1, "addr6", 1'b0);
        wr(3'd2, 32'hFFFF_FFFF);
        rd(3'd2, 32'd7, 1'b1, "mask_trunc", 1'b0);
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd7, 32'd0, 1'b1, "addr7", 1'b0);

        // Reset mid-debounce discards the count; held input rises with full latency
        wr(3'd3, 32'd7);
        in0 = 3'b000;
        idle(10);
        in0 = 3'b001;
        idle(3);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {irq0, rd0}, 33'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wr(3'd2, 32'd1);
        for (int i = 1; i < 9; i++)
            rd(3'd0, (i >= 6) ? 32'd1 : 32'd0, i >= 6, $sformatf("post_rst_e%0d", i), 1'b0);

        idle(2);
        if (exp_q.size() != 0) chk("queue_drain", 33'(exp_q.size()), 33'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/peripheral_system_debounced_pio.md
PERIPHERAL_SYSTEM_DEBOUNCED_PIO -- requirements
Module: peripheral_system_debounced_pio

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the number of input bits (legal 1..32).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000, giving the stable-cycle count for debounce; 0 means bypass (legal 0..65535).
REQ-003 The block SHALL have parameter RISE_EN_RESET, default all ones (WIDTH bits), giving the reset value of rise_en.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port address, input, 3 bits: register word select.
REQ-007 The block SHALL have port chipselect, input, 1 bit: slave select.
REQ-008 The block SHALL have port write_n, input, 1 bit: active-low write strobe, qualified by chipselect.
REQ-009 The block SHALL have port writedata, input, 32 bits: write data; bits above WIDTH-1 are ignored.
REQ-010 The block SHALL have port in_port, input, WIDTH bits: asynchronous external inputs.
REQ-011 The block SHALL have port irq, output, 1 bit: level interrupt.
REQ-012 The block SHALL have port readdata, output, 32 bits: registered read data, zero-extended above WIDTH-1.

Function
REQ-013 Each in_port bit SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-014 Each bit SHALL have a counter cnt of width clog2(DEBOUNCE_CYCLES+1) and a debounced flop deb.
REQ-015 Each clock, for each bit: s2==deb -> cnt<=0; s2!=deb and cnt==DEBOUNCE_CYCLES-1 -> deb<=s2, cnt<=0; otherwise cnt<=cnt+1.
REQ-016 An input change stable before clock edge k SHALL appear on deb at edge k+1+DEBOUNCE_CYCLES; any pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave deb unchanged.
REQ-017 When DEBOUNCE_CYCLES==0, the counters SHALL be omitted and deb<=s2 every clock.
REQ-018 A rise event SHALL be a deb transition 0->1 with rise_en[i]=1; a fall event SHALL be a transition 1->0 with fall_en[i]=1; each event SHALL set edge_capture[i] at the following clock edge.
REQ-019 Register map (write = chipselect & ~write_n): 0 deb (RO); 1 s2 raw (RO); 2 irq_mask (RW); 3 edge_capture (read; write-1-to-clear per bit); 4 rise_en (RW); 5 fall_en (RW); 6-7 read 0, writes ignored.
REQ-020 Writes to read-only addresses SHALL have no effect.
REQ-021 A write-1-to-clear of edge_capture[i] in the same cycle as a new event on bit i SHALL leave the bit set (set wins); writing 0 to a bit SHALL leave it unchanged.
REQ-022 readdata SHALL update every clock from the current address, independent of chipselect, giving one-cycle read latency.
REQ-023 irq SHALL equal OR-reduce(edge_capture & irq_mask), combinational from registers, with no additional latency.
REQ-024 Changing rise_en/fall_en SHALL NOT clear captured bits or alter deb/cnt state.

Reset
REQ-025 On reset_n low: s1, s2, deb, cnt, irq_mask, edge_capture, fall_en and readdata SHALL be 0; rise_en SHALL be RISE_EN_RESET; irq SHALL be 0.
REQ-026 Reset assertion mid-debounce SHALL discard the count; after release, an input held at 1 SHALL produce a rise event per REQ-016 timing.
REQ-027 No edge event SHALL be generated by the reset release itself.

Verification (WIDTH=3, DEBOUNCE_CYCLES=4 unless stated)
REQ-028 in_port[0] 0->1 before edge 0, held -> deb[0]=1 after edge 5, edge_capture=3'b001 after edge 6, irq=1 once irq_mask=3'b001.
REQ-029 in_port[1] high for 3 clocks then low -> deb, edge_capture and irq stay 0 throughout.
REQ-030 fall_en=3'b100, rise_en=0; in_port[2] 1->0 after settling high -> edge_capture=3'b100; write 3'b100 to address 3 -> edge_capture=0 and irq=0 the next cycle.
REQ-031 Write-1-to-clear to address 3 in the exact cycle of a new rise on bit 0 -> edge_capture[0] remains 1.
REQ-032 Read address 6, then address 2 after writing 0xFFFFFFFF -> readdata=0 one cycle after the first read, then 0x00000007.
REQ-033 DEBOUNCE_CYCLES=0: in_port[0] rises before edge 0 -> deb[0]=1 after edge 2, edge_capture[0]=1 after edge 3.
